// File: rtl/vga_timing_gen.sv
// Raster timing source: DrawX/DrawY counters with zero-latency flags, plus hs/vs/blank_d
// delayed by PIPE_DELAY stages so they line up with registered pixel color from renderers.
module vga_timing_gen #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int SYNC_POL   = 0,
   parameter int PIPE_DELAY = 1
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       blank,
   output logic       line_start,
   output logic       frame_start,
   output logic       hs,
   output logic       vs,
   output logic       blank_d
);

   localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int H_HS_ON  = H_VISIBLE + H_FRONT;
   localparam int H_HS_OFF = H_HS_ON + H_SYNC;
   localparam int V_VS_ON  = V_VISIBLE + V_FRONT;
   localparam int V_VS_OFF = V_VS_ON + V_SYNC;
   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic SYNC_ACT = (SYNC_POL != 0);

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
   end
   if (PIPE_DELAY < 0 || PIPE_DELAY > 3) begin : g_bad_delay
      $error("vga_timing_gen: PIPE_DELAY must be 0..3");
   end

   logic [9:0] x_next;
   logic [9:0] y_next;
   logic       hs_now;
   logic       vs_now;

   always_comb begin
      x_next = DrawX + 10'd1;
      y_next = DrawY;
      if (DrawX == H_LAST) begin
         x_next = '0;
         y_next = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
      end
   end

   // Flags are derived from the next counter values so they land together with them.
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         DrawX       <= '0;
         DrawY       <= '0;
         blank       <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         DrawX       <= x_next;
         DrawY       <= y_next;
         blank       <= (int'(x_next) < H_VISIBLE) && (int'(y_next) < V_VISIBLE);
         line_start  <= (x_next == 10'd0);
         frame_start <= (x_next == 10'd0) && (y_next == 10'd0);
      end
   end

   // vs is taken from DrawY only, so it can change only when the line changes.
   always_comb begin
      hs_now = ((int'(DrawX) >= H_HS_ON) && (int'(DrawX) < H_HS_OFF)) ? SYNC_ACT : ~SYNC_ACT;
      vs_now = ((int'(DrawY) >= V_VS_ON) && (int'(DrawY) < V_VS_OFF)) ? SYNC_ACT : ~SYNC_ACT;
   end

   if (PIPE_DELAY == 0) begin : g_no_delay
      assign hs      = hs_now;
      assign vs      = vs_now;
      assign blank_d = blank;
   end else begin : g_delay
      logic [PIPE_DELAY-1:0] hs_pipe;
      logic [PIPE_DELAY-1:0] vs_pipe;
      logic [PIPE_DELAY-1:0] bl_pipe;

      always_ff @(posedge vga_clk) begin
         if (!reset_n) begin
            hs_pipe <= {PIPE_DELAY{~SYNC_ACT}};
            vs_pipe <= {PIPE_DELAY{~SYNC_ACT}};
            bl_pipe <= '0;
         end else begin
            hs_pipe[0] <= hs_now;
            vs_pipe[0] <= vs_now;
            bl_pipe[0] <= blank;
            for (int i = 1; i < PIPE_DELAY; i++) begin
               hs_pipe[i] <= hs_pipe[i-1];
               vs_pipe[i] <= vs_pipe[i-1];
               bl_pipe[i] <= bl_pipe[i-1];
            end
         end
      end

      assign hs      = hs_pipe[PIPE_DELAY-1];
      assign vs      = vs_pipe[PIPE_DELAY-1];
      assign blank_d = bl_pipe[PIPE_DELAY-1];
   end

endmodule
